// File: rtl/gam_pattern_feeder.sv
// gam_pattern_feeder
// Upstream stage of the GAM memory layer. A host loads (node vector, class)
// patterns into a FIFO while the block is idle. After start, the block hands
// one pattern to the memory layer for each READY handshake on x/c. It drives
// the LEARNING/RECALL select and raises learning_done together with the final
// pattern.
module gam_pattern_feeder #(
    parameter int NODE_W  = 128,
    parameter int CLASS_W = 32,
    parameter int DEPTH   = 20,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [NODE_W-1:0]  ld_node,
    input  logic [CLASS_W-1:0] ld_class,
    input  logic               start,
    input  logic               mode,
    input  logic               ready_wait,
    output logic [NODE_W-1:0]  x,
    output logic [CLASS_W-1:0] c,
    output logic               learning_done,
    output logic               learning_recall,
    output logic               busy,
    output logic [CNT_W-1:0]   count,
    output logic               err_zero
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               armed_reg;
    logic [NODE_W-1:0]  x_reg;
    logic [CLASS_W-1:0] c_reg;
    logic               done_reg;
    logic               recall_reg;
    logic               err_zero_reg;

    // Pattern storage. It has no reset: a reset only clears the pointers and
    // the count, so the old contents become unreachable.
    logic [NODE_W-1:0]  node_mem  [DEPTH];
    logic [CLASS_W-1:0] class_mem [DEPTH];

    logic             ld_accept;
    logic             ld_zero;
    logic             ld_write;
    logic             issue;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;

    // Load, issue and pointer-advance decisions.
    always_comb begin
        ld_accept   = ld_valid && ld_ready;
        ld_zero     = (ld_node == '0) || (ld_class == '0);
        ld_write    = ld_accept && !ld_zero;
        issue       = (state_reg == FEED) && ready_wait && armed_reg;
        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    // Write accepted, non-zero patterns into the buffer.
    always_ff @(posedge clk) begin
        if (ld_write) begin
            node_mem[wr_ptr_reg]  <= ld_node;
            class_mem[wr_ptr_reg] <= ld_class;
        end
    end

    // Control FSM. It also holds the registered x/c and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            armed_reg    <= 1'b0;
            x_reg        <= '0;
            c_reg        <= '0;
            done_reg     <= 1'b0;
            recall_reg   <= 1'b0;
            err_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ld_accept && ld_zero) begin
                        err_zero_reg <= 1'b1;
                    end
                    if (ld_write) begin
                        wr_ptr_reg <= wr_ptr_next;
                        count_reg  <= count_reg + CNT_W'(1);
                    end
                    // A load in the same cycle as start counts toward the
                    // start decision.
                    if (start && ((count_reg != '0) || ld_write)) begin
                        recall_reg <= mode;
                        armed_reg  <= 1'b1;
                        state_reg  <= FEED;
                    end
                end
                FEED: begin
                    // Re-arm on WAIT. Held READY then yields one issue per
                    // WAIT->READY transition.
                    if (!ready_wait) begin
                        armed_reg <= 1'b1;
                    end
                    if (issue) begin
                        x_reg      <= node_mem[rd_ptr_reg];
                        c_reg      <= class_mem[rd_ptr_reg];
                        rd_ptr_reg <= rd_ptr_next;
                        count_reg  <= count_reg - CNT_W'(1);
                        armed_reg  <= 1'b0;
                        if (count_reg == CNT_W'(1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready        = (state_reg == IDLE) && (count_reg < CNT_W'(DEPTH));
    assign busy            = (state_reg == FEED);
    assign x               = x_reg;
    assign c               = c_reg;
    assign learning_done   = done_reg;
    assign learning_recall = recall_reg;
    assign count           = count_reg;
    assign err_zero        = err_zero_reg;

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Directed testbench for gam_pattern_feeder.
module tb_gam_pattern_feeder;

    localparam int NW = 128;
    localparam int CW = 32;
    localparam int DP = 20;
    localparam int KW = $clog2(DP + 1);

    logic          clk;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [NW-1:0] ld_node;
    logic [CW-1:0] ld_class;
    logic          start;
    logic          mode;
    logic          ready_wait;
    logic [NW-1:0] x;
    logic [CW-1:0] c;
    logic          learning_done;
    logic          learning_recall;
    logic          busy;
    logic [KW-1:0] count;
    logic          err_zero;

    int errors = 0;
    int checks = 0;

    gam_pattern_feeder #(.NODE_W(NW), .CLASS_W(CW), .DEPTH(DP)) dut (
        .clk             (clk),
        .reset           (reset),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_node         (ld_node),
        .ld_class        (ld_class),
        .start           (start),
        .mode            (mode),
        .ready_wait      (ready_wait),
        .x               (x),
        .c               (c),
        .learning_done   (learning_done),
        .learning_recall (learning_recall),
        .busy            (busy),
        .count           (count),
        .err_zero        (err_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] node;
        logic [CW-1:0] cls;
        logic [NW-1:0] exp_x;
        logic [CW-1:0] exp_c;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [NW-1:0] n, input logic [CW-1:0] cl);
        ld_valid = 1'b1;
        ld_node  = n;
        ld_class = cl;
        tick();
        ld_valid = 1'b0;
        ld_node  = '0;
        ld_class = '0;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // One READY pulse, then one WAIT cycle that re-arms the next issue.
    task automatic issue_one(input logic [NW-1:0] ex, input logic [CW-1:0] ec, input string nm);
        ready_wait = 1'b1;
        tick();
        $display("issue %s: x=%0h c=%0d done=%0b", nm, x, c, learning_done);
        chk({nm, "_x"}, x, ex);
        chk({nm, "_c"}, 128'(c), 128'(ec));
        ready_wait = 1'b0;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_node    = '0;
        ld_class   = '0;
        start      = 1'b0;
        mode       = 1'b0;
        ready_wait = 1'b0;

        vecs[0] = '{128'd1234,            32'd1, 128'd1234,            32'd1};
        vecs[1] = '{128'd22313,           32'd1, 128'd22313,           32'd1};
        vecs[2] = '{128'd324234,          32'd1, 128'd324234,          32'd1};
        vecs[3] = '{128'd123000000000000, 32'd1, 128'd123000000000000, 32'd1};
        vecs[4] = '{{32'd54, 32'd54754654, 32'd32432432, 32'd675656}, 32'd1,
                    {32'd54, 32'd54754654, 32'd32432432, 32'd675656}, 32'd1};

        // Reset state
        #3;
        chk("rst_x", x, '0);
        chk("rst_c", 128'(c), '0);
        chk("rst_count", 128'(count), '0);
        chk("rst_ld_ready", 128'(ld_ready), 128'(1));
        chk("rst_busy", 128'(busy), '0);
        chk("rst_done", 128'(learning_done), '0);
        chk("rst_err", 128'(err_zero), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Test 1: five class-1 patterns, READY toggled every 5 clocks
        for (int i = 0; i < 5; i++) load(vecs[i].node, vecs[i].cls);
        chk("t1_count_loaded", 128'(count), 128'(5));
        do_start(1'b0);
        chk("t1_busy", 128'(busy), 128'(1));
        for (int i = 0; i < 5; i++) begin
            chk("t1_x_before", x, (i == 0) ? '0 : vecs[i-1].exp_x);
            ready_wait = 1'b1;
            tick();
            $display("issue t1[%0d]: x=%0h c=%0d done=%0b", i, x, c, learning_done);
            chk("t1_x", x, vecs[i].exp_x);
            chk("t1_c", 128'(c), 128'(vecs[i].exp_c));
            chk("t1_done", 128'(learning_done), (i == 4) ? 128'(1) : '0);
            repeat (4) tick();
            chk("t1_x_hold", x, vecs[i].exp_x);
            ready_wait = 1'b0;
            repeat (5) tick();
        end
        chk("t1_count_end", 128'(count), '0);
        chk("t1_recall", 128'(learning_recall), '0);
        chk("t1_busy_end", 128'(busy), '0);
        chk("t1_done_hold", 128'(learning_done), 128'(1));
        do_start(1'b0);
        chk("t1_done_clr", 128'(learning_done), '0);
        chk("t1_x_keep", x, vecs[4].exp_x);
        chk("t1_ld_ready_idle", 128'(ld_ready), 128'(1));

        // Test 2: held READY issues once; a WAIT->READY toggle issues again
        load(128'h11, 32'd2);
        load(128'h22, 32'd2);
        do_start(1'b0);
        ready_wait = 1'b1;
        tick();
        chk("t2_x_first", x, 128'h11);
        ld_valid = 1'b1;
        ld_node  = 128'h99;
        ld_class = 32'd9;
        chk("t2_ld_ready_feed", 128'(ld_ready), '0);
        repeat (10) tick();
        ld_valid = 1'b0;
        chk("t2_x_held", x, 128'h11);
        chk("t2_count_held", 128'(count), 128'(1));
        ready_wait = 1'b0;
        tick();
        ready_wait = 1'b1;
        tick();
        chk("t2_x_second", x, 128'h22);
        chk("t2_done", 128'(learning_done), 128'(1));
        ready_wait = 1'b0;
        do_start(1'b0);

        // Test 3: zero node / zero class loads are rejected
        load('0, 32'd2);
        load(128'd7, '0);
        chk("t3_err", 128'(err_zero), 128'(1));
        chk("t3_count", 128'(count), '0);
        do_start(1'b0);
        chk("t3_busy", 128'(busy), '0);
        chk("t3_ld_ready", 128'(ld_ready), 128'(1));

        // Test 4: fill to DEPTH, drain, then wrap
        do_reset();
        for (int k = 1; k <= DP; k++) load(128'(k), 32'(k / 5 + 1));
        chk("t4_count_full", 128'(count), 128'(20));
        chk("t4_ld_ready_full", 128'(ld_ready), '0);
        load(128'd99, 32'd9);
        chk("t4_count_21st", 128'(count), 128'(20));
        do_start(1'b0);
        for (int k = 1; k <= DP; k++) issue_one(128'(k), 32'(k / 5 + 1), $sformatf("t4_%0d", k));
        chk("t4_done", 128'(learning_done), 128'(1));
        chk("t4_count_empty", 128'(count), '0);
        do_start(1'b0);
        load(128'd100, 32'd3);
        load(128'd101, 32'd3);
        load(128'd102, 32'd3);
        do_start(1'b0);
        issue_one(128'd100, 32'd3, "t4_wrap0");
        issue_one(128'd101, 32'd3, "t4_wrap1");
        issue_one(128'd102, 32'd3, "t4_wrap2");
        chk("t4_wrap_done", 128'(learning_done), 128'(1));
        do_start(1'b0);

        // Test 5: asynchronous reset in the middle of FEED
        for (int i = 0; i < 5; i++) load(vecs[i].node, vecs[i].cls);
        do_start(1'b0);
        issue_one(vecs[0].exp_x, 32'd1, "t5_0");
        issue_one(vecs[1].exp_x, 32'd1, "t5_1");
        #2;
        reset = 1'b1;
        #1;
        chk("t5_x", x, '0);
        chk("t5_c", 128'(c), '0);
        chk("t5_count", 128'(count), '0);
        chk("t5_busy", 128'(busy), '0);
        chk("t5_done", 128'(learning_done), '0);
        chk("t5_ld_ready", 128'(ld_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Test 6: RECALL mode
        load(128'hA1, 32'd5);
        load(128'hA2, 32'd5);
        do_start(1'b1);
        chk("t6_recall_feed", 128'(learning_recall), 128'(1));
        issue_one(128'hA1, 32'd5, "t6_0");
        issue_one(128'hA2, 32'd5, "t6_1");
        chk("t6_done", 128'(learning_done), 128'(1));
        chk("t6_recall_done", 128'(learning_recall), 128'(1));
        do_start(1'b0);
        chk("t6_done_clr", 128'(learning_done), '0);
        chk("t6_busy", 128'(busy), '0);
        chk("t6_ld_ready", 128'(ld_ready), 128'(1));

        // Test 7: start together with the first load from an empty buffer
        ld_valid = 1'b1;
        ld_node  = 128'h5A;
        ld_class = 32'd4;
        start    = 1'b1;
        mode     = 1'b0;
        tick();
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("t7_busy", 128'(busy), 128'(1));
        chk("t7_count", 128'(count), 128'(1));
        chk("t7_recall", 128'(learning_recall), '0);
        issue_one(128'h5A, 32'd4, "t7_0");
        chk("t7_done", 128'(learning_done), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
